// File: rtl/dmem_responder_pkg.sv
// Shared widths, FSM state encoding and the address range check for the
// data-memory responder and its storage array.
package dmem_responder_pkg;

  localparam int WORD_W     = 16;
  localparam int DMEM_DEPTH = 1024;
  localparam int CNT_W      = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  // Range check runs on the full word index, before any truncation to the array width.
  function automatic logic addr_err(input logic [WORD_W-1:0] addr, input int depth);
    logic [31:0] widx;
    widx = {17'd0, addr[WORD_W-1:1]};
    return addr[0] | (widx >= 32'(depth));
  endfunction

endpackage

// File: rtl/dmem_array.sv
// DEPTH x WIDTH data store: synchronous write and registered read, both strobed
// by the responder only at its commit edge. Contents are never reset.
module dmem_array
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH = DMEM_DEPTH,
  parameter int WIDTH = WORD_W,
  parameter int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1
) (
  input  logic             clock,
  input  logic             we_i,
  input  logic             re_i,
  input  logic [AW-1:0]    addr_i,
  input  logic [WIDTH-1:0] wdata_i,
  output logic [WIDTH-1:0] rdata_o
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [WIDTH-1:0] rdata_q;

  always_ff @(posedge clock) begin
    if (we_i) begin
      mem_q[addr_i] <= wdata_i;
    end
    if (re_i) begin
      rdata_q <= mem_q[addr_i];
    end
  end

  assign rdata_o = rdata_q;

endmodule

// File: rtl/dmem_responder.sv
// Fixed-latency responder for the CPU data-memory port: one outstanding
// load/store, valid/ready on both channels, misaligned/out-of-range flagged.
module dmem_responder
  import dmem_responder_pkg::*;
#(
  parameter int DEPTH   = DMEM_DEPTH,
  parameter int LATENCY = 2
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [WORD_W-1:0] req_addr,
  input  logic [WORD_W-1:0] req_wdata,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic [WORD_W-1:0] resp_rdata,
  output logic              resp_err
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  state_e            state_q, state_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic              we_q, we_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              err_q, err_d;
  logic              rsel_q, rsel_d;
  logic              ready_q, ready_d;
  logic              valid_q, valid_d;

  logic              commit_err;
  logic              mem_we, mem_re;
  logic [AW-1:0]     word_idx;
  logic [WORD_W-1:0] mem_rdata;

  assign commit_err = addr_err(addr_q, DEPTH);
  assign word_idx   = addr_q[AW:1];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    err_d   = err_q;
    rsel_d  = rsel_q;
    mem_we  = 1'b0;
    mem_re  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (req_valid && ready_q) begin
          we_d    = req_we;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          cnt_d   = CNT_W'(LATENCY - 1);
          state_d = ST_WAIT;
        end
      end
      ST_WAIT: begin
        if (cnt_q != '0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          err_d   = commit_err;
          rsel_d  = ~we_q & ~commit_err;
          mem_we  = we_q & ~commit_err;
          mem_re  = ~we_q & ~commit_err;
          state_d = ST_RESP;
        end
      end
      ST_RESP: begin
        if (resp_ready) begin
          err_d   = 1'b0;
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
    // Handshake flags are registered copies of the next state so that they
    // read 0 throughout reset and carry no path from any input.
    ready_d = (state_d == ST_IDLE);
    valid_d = (state_d == ST_RESP);
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      err_q   <= 1'b0;
      rsel_q  <= 1'b0;
      ready_q <= 1'b0;
      valid_q <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      err_q   <= err_d;
      rsel_q  <= rsel_d;
      ready_q <= ready_d;
      valid_q <= valid_d;
    end
  end

  dmem_array #(
    .DEPTH (DEPTH),
    .WIDTH (WORD_W),
    .AW    (AW)
  ) u_array (
    .clock   (clock),
    .we_i    (mem_we),
    .re_i    (mem_re),
    .addr_i  (word_idx),
    .wdata_i (wdata_q),
    .rdata_o (mem_rdata)
  );

  // Array read data only moves on a load commit, so gating it by the last
  // commit's load flag both zeroes stores/errors and holds the value after handshake.
  assign resp_rdata = rsel_q ? mem_rdata : '0;
  assign resp_err   = err_q;
  assign req_ready  = ready_q;
  assign resp_valid = valid_q;

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: three instances at LATENCY 2, 1 and 15.
module tb_dmem_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset_n;
  logic        req_valid  [3];
  logic        req_we     [3];
  logic        resp_ready [3];
  logic [15:0] req_addr   [3];
  logic [15:0] req_wdata  [3];
  logic        req_ready  [3];
  logic        resp_valid [3];
  logic        resp_err   [3];
  logic [15:0] resp_rdata [3];

  int total = 0;
  int bad   = 0;

  function automatic int lat_of(input int k);
    return (k == 0) ? 2 : ((k == 1) ? 1 : 15);
  endfunction

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      dmem_responder #(
        .DEPTH   (1024),
        .LATENCY ((gi == 0) ? 2 : ((gi == 1) ? 1 : 15))
      ) u_dut (
        .clock      (clk),
        .reset_n    (reset_n),
        .req_valid  (req_valid[gi]),
        .req_ready  (req_ready[gi]),
        .req_we     (req_we[gi]),
        .req_addr   (req_addr[gi]),
        .req_wdata  (req_wdata[gi]),
        .resp_valid (resp_valid[gi]),
        .resp_ready (resp_ready[gi]),
        .resp_rdata (resp_rdata[gi]),
        .resp_err   (resp_err[gi])
      );
    end
  endgenerate

  // One full transaction; request fields are scrambled right after acceptance.
  task automatic do_txn(input int k, input logic we, input logic [15:0] addr,
                        input logic [15:0] wdata, output logic [15:0] rdata,
                        output logic err, output int lat);
    int n;
    rdata = 'x;
    err   = 'x;
    lat   = -1;
    @(negedge clk);
    req_valid[k] = 1'b1;
    req_we[k]    = we;
    req_addr[k]  = addr;
    req_wdata[k] = wdata;
    n = 0;
    while (req_ready[k] !== 1'b1 && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (req_ready[k] !== 1'b1) begin
      total++; bad++;
      $display("FAIL accept_timeout dut=%0d addr=%h req_ready=%b required=1", k, addr, req_ready[k]);
      req_valid[k] = 1'b0;
      return;
    end
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    req_we[k]    = ~we;
    req_addr[k]  = 16'hFFFF ^ addr;
    req_wdata[k] = ~wdata;
    lat = 0;
    while (resp_valid[k] !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
    if (resp_valid[k] !== 1'b1) begin
      total++; bad++;
      $display("FAIL resp_timeout dut=%0d addr=%h resp_valid=%b required=1", k, addr, resp_valid[k]);
      return;
    end
    rdata = resp_rdata[k];
    err   = resp_err[k];
    resp_ready[k] = 1'b1;
    @(posedge clk); #1;
    resp_ready[k] = 1'b0;
    total++;
    if (resp_valid[k] !== 1'b0) begin
      bad++;
      $display("FAIL resp_drop dut=%0d resp_valid=%b required=0", k, resp_valid[k]);
    end
  endtask

  task automatic test_reset();
    reset_n = 1'b0;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b1; req_we[k] = 1'b0; req_addr[k] = 16'h0000;
      req_wdata[k] = 16'h0000; resp_ready[k] = 1'b0;
    end
    repeat (3) @(posedge clk);
    #1;
    for (int k = 0; k < 3; k++) begin
      total++; if (req_ready[k] !== 1'b0) begin bad++; $display("FAIL rst_req_ready dut=%0d got=%b want=0", k, req_ready[k]); end
      total++; if (resp_valid[k] !== 1'b0) begin bad++; $display("FAIL rst_resp_valid dut=%0d got=%b want=0", k, resp_valid[k]); end
      total++; if (resp_rdata[k] !== 16'h0000) begin bad++; $display("FAIL rst_resp_rdata dut=%0d got=%h want=0000", k, resp_rdata[k]); end
      total++; if (resp_err[k] !== 1'b0) begin bad++; $display("FAIL rst_resp_err dut=%0d got=%b want=0", k, resp_err[k]); end
    end
    @(negedge clk);
    reset_n = 1'b1;
    #1;
    total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL rel_ready_early got=%b want=0", req_ready[0]); end
    @(posedge clk); #1;
    for (int k = 0; k < 3; k++) begin
      req_valid[k] = 1'b0;
      total++; if (req_ready[k] !== 1'b1) begin bad++; $display("FAIL rel_ready dut=%0d got=%b want=1", k, req_ready[k]); end
    end
  endtask

  task automatic test_store_load();
    logic [15:0] rd; logic er; int lt;
    do_txn(0, 1'b1, 16'h0004, 16'h000F, rd, er, lt);
    total++; if (lt !== 2) begin bad++; $display("FAIL st_latency got=%0d want=2", lt); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL st_err got=%b want=0", er); end
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL st_rdata got=%h want=0000", rd); end
    do_txn(0, 1'b0, 16'h0004, 16'h0000, rd, er, lt);
    total++; if (lt !== 2) begin bad++; $display("FAIL ld_latency got=%0d want=2", lt); end
    total++; if (rd !== 16'h000F) begin bad++; $display("FAIL ld_rdata got=%h want=000f", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL ld_err got=%b want=0", er); end
  endtask

  task automatic test_misaligned();
    logic [15:0] rd; logic er; int lt;
    do_txn(0, 1'b1, 16'h0002, 16'h5A5A, rd, er, lt);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_pre_err got=%b want=0", er); end
    do_txn(0, 1'b1, 16'h0003, 16'hBEEF, rd, er, lt);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL mis_err got=%b want=1", er); end
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL mis_rdata got=%h want=0000", rd); end
    total++; if (lt !== 2) begin bad++; $display("FAIL mis_latency got=%0d want=2", lt); end
    do_txn(0, 1'b0, 16'h0002, 16'h0000, rd, er, lt);
    total++; if (rd !== 16'h5A5A) begin bad++; $display("FAIL mis_after_rdata got=%h want=5a5a", rd); end
    total++; if (er !== 1'b0) begin bad++; $display("FAIL mis_after_err got=%b want=0", er); end
  endtask

  task automatic test_range();
    logic [15:0] rd; logic er; int lt;
    do_txn(0, 1'b1, 16'h0000, 16'h0A0A, rd, er, lt);
    do_txn(0, 1'b0, 16'h0002, 16'h0000, rd, er, lt);
    total++; if (rd !== 16'h5A5A) begin bad++; $display("FAIL rng_pre_rdata got=%h want=5a5a", rd); end
    do_txn(0, 1'b0, 16'h0800, 16'h0000, rd, er, lt);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL rng_ld800_err got=%b want=1", er); end
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rng_ld800_rdata got=%h want=0000", rd); end
    do_txn(0, 1'b1, 16'h0800, 16'h1111, rd, er, lt);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL rng_st800_err got=%b want=1", er); end
    do_txn(0, 1'b0, 16'h0000, 16'h0000, rd, er, lt);
    total++; if (rd !== 16'h0A0A) begin bad++; $display("FAIL rng_word0 got=%h want=0a0a", rd); end
    do_txn(0, 1'b1, 16'h07FE, 16'h7777, rd, er, lt);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rng_st7fe_err got=%b want=0", er); end
    do_txn(0, 1'b0, 16'h07FE, 16'h0000, rd, er, lt);
    total++; if (er !== 1'b0) begin bad++; $display("FAIL rng_ld7fe_err got=%b want=0", er); end
    total++; if (rd !== 16'h7777) begin bad++; $display("FAIL rng_ld7fe_rdata got=%h want=7777", rd); end
    do_txn(0, 1'b0, 16'hFFFE, 16'h0000, rd, er, lt);
    total++; if (er !== 1'b1) begin bad++; $display("FAIL rng_ldfffe_err got=%b want=1", er); end
    total++; if (rd !== 16'h0000) begin bad++; $display("FAIL rng_ldfffe_rdata got=%h want=0000", rd); end
  endtask

  task automatic test_back_to_back();
    logic [15:0] rd; logic er; int lt; int n;
    do_txn(0, 1'b1, 16'h0020, 16'hC0DE, rd, er, lt);
    @(negedge clk);
    req_valid[0] = 1'b1; req_we[0] = 1'b0; req_addr[0] = 16'h0020; req_wdata[0] = 16'h0000;
    @(posedge clk); #1;
    req_we[0] = 1'b1; req_addr[0] = 16'h0022; req_wdata[0] = 16'h2222;
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL bp_latency got=%0d want=2", n); end
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      total++; if (resp_valid[0] !== 1'b1) begin bad++; $display("FAIL bp_valid cyc=%0d got=%b want=1", c, resp_valid[0]); end
      total++; if (resp_rdata[0] !== 16'hC0DE) begin bad++; $display("FAIL bp_rdata cyc=%0d got=%h want=c0de", c, resp_rdata[0]); end
      total++; if (resp_err[0] !== 1'b0) begin bad++; $display("FAIL bp_err cyc=%0d got=%b want=0", c, resp_err[0]); end
      total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_req_ready cyc=%0d got=%b want=0", c, req_ready[0]); end
    end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    total++; if (resp_valid[0] !== 1'b0) begin bad++; $display("FAIL bp_hs_valid got=%b want=0", resp_valid[0]); end
    total++; if (req_ready[0] !== 1'b1) begin bad++; $display("FAIL bp_hs_ready got=%b want=1", req_ready[0]); end
    @(posedge clk); #1;
    req_valid[0] = 1'b0;
    total++; if (req_ready[0] !== 1'b0) begin bad++; $display("FAIL bp_second_accept got=%b want=0", req_ready[0]); end
    n = 0;
    while (resp_valid[0] !== 1'b1 && n < 40) begin @(posedge clk); #1; n++; end
    total++; if (n !== 2) begin bad++; $display("FAIL bp2_latency got=%0d want=2", n); end
    total++; if (resp_rdata[0] !== 16'h0000) begin bad++; $display("FAIL bp2_rdata got=%h want=0000", resp_rdata[0]); end
    resp_ready[0] = 1'b1;
    @(posedge clk); #1;
    resp_ready[0] = 1'b0;
    do_txn(0, 1'b0, 16'h0022, 16'h0000, rd, er, lt);
    total++; if (rd !== 16'h2222) begin bad++; $display("FAIL bp2_readback got=%h want=2222", rd); end
  endtask

  task automatic test_reset_in_wait(input int k);
    logic [15:0] rd; logic er; int lt; int lat; logic seen;
    logic [15:0] pre;
    lat = lat_of(k);
    pre = 16'h0100 + 16'(k);
    do_txn(k, 1'b1, 16'h0010, pre, rd, er, lt);
    total++; if (lt !== lat) begin bad++; $display("FAIL rw_st_latency dut=%0d got=%0d want=%0d", k, lt, lat); end
    @(negedge clk);
    req_valid[k] = 1'b1; req_we[k] = 1'b1; req_addr[k] = 16'h0010; req_wdata[k] = 16'h1234;
    @(posedge clk); #1;
    req_valid[k] = 1'b0;
    total++; if (req_ready[k] !== 1'b0) begin bad++; $display("FAIL rw_accept dut=%0d got=%b want=0", k, req_ready[k]); end
    reset_n = 1'b0;
    #2;
    reset_n = 1'b1;
    seen = 1'b0;
    repeat (lat + 3) begin
      @(posedge clk); #1;
      if (resp_valid[k] === 1'b1) seen = 1'b1;
    end
    total++; if (seen !== 1'b0) begin bad++; $display("FAIL rw_no_resp dut=%0d got=%b want=0", k, seen); end
    total++; if (req_ready[k] !== 1'b1) begin bad++; $display("FAIL rw_ready dut=%0d got=%b want=1", k, req_ready[k]); end
    do_txn(k, 1'b0, 16'h0010, 16'h0000, rd, er, lt);
    total++; if (rd !== pre) begin bad++; $display("FAIL rw_readback dut=%0d got=%h want=%h", k, rd, pre); end
    total++; if (lt !== lat) begin bad++; $display("FAIL rw_ld_latency dut=%0d got=%0d want=%0d", k, lt, lat); end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_store_load();
    test_misaligned();
    test_range();
    test_back_to_back();
    test_reset_in_wait(0);
    test_reset_in_wait(1);
    test_reset_in_wait(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
